distance_pulse_gen: RTL and testbench
=====================================

DISTANCE_PULSE_GEN -- requirements
Module: distance_pulse_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive clk cycles wheel_in must hold a new level before it is accepted.
REQ-002 SHALL have parameter STOP_TIMEOUT, default 1000: clk cycles with no accepted revolution before the vehicle counts as stopped.
REQ-003 SHALL have port clk  input  1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port en  input  1: trip active; low holds the block idle.
REQ-006 SHALL have port wheel_in  input  1: raw, asynchronous wheel sensor; one rising edge per wheel revolution.
REQ-007 SHALL have port circ_mm  input  12: wheel circumference in millimetres, unsigned, binary.
REQ-008 SHALL have port ten_meter_pulse  output  1: one-cycle high pulse per completed 10 m; feeds the fare block's ten_meter_pulse input.
REQ-009 SHALL have port wait_en  output  1: high while the vehicle is stopped; feeds the fare block's wait_en input.
REQ-010 SHALL have port moving  output  1: high in state MOVING.

Function
REQ-011 SHALL pass wheel_in through a 2-flop synchronizer before any other use.
REQ-012 SHALL update the debounced level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts the count.
REQ-013 SHALL register a revolution event for exactly one cycle on each 0->1 transition of the debounced level.
REQ-014 SHALL keep a 14-bit accumulator acc_mm; on a revolution event with en high: sum = acc_mm + circ_mm; if sum >= 10000 then acc_mm = sum - 10000 and ten_meter_pulse = 1 the following cycle, else acc_mm = sum.
REQ-015 SHALL sample circ_mm only on the revolution-event cycle; changes at other times have no effect.
REQ-016 SHALL treat circ_mm = 0 as valid: revolutions still count for motion, no distance accumulates, no pulse is generated.
REQ-017 SHALL generate at most one ten_meter_pulse per revolution (4095 < 10000); the remainder carries over with no loss.
REQ-018 SHALL run a 26-bit idle counter that clears on each revolution event, increments otherwise, and saturates at STOP_TIMEOUT.
REQ-019 SHALL implement states IDLE, STOPPED, MOVING: IDLE->STOPPED when en rises; STOPPED->MOVING on a revolution event; MOVING->STOPPED when the idle counter reaches STOP_TIMEOUT; any state->IDLE when en is low.
REQ-020 SHALL give the revolution event priority when it coincides with idle counter reaching STOP_TIMEOUT: the state stays or becomes MOVING.
REQ-021 SHALL drive wait_en = 1 only in STOPPED, and moving = 1 only in MOVING, both registered.
REQ-022 SHALL, in IDLE, clear acc_mm and the idle counter and hold ten_meter_pulse at 0; revolutions are ignored.
REQ-023 SHALL suppress ten_meter_pulse for a pulse due on the cycle en falls.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force state IDLE, acc_mm 0, idle counter 0, debounce counter 0, synchronizer and debounced level 0, and outputs ten_meter_pulse 0, wait_en 0, moving 0.
REQ-025 SHALL resume from IDLE after rst_n rises and never generate a revolution event from the reset-to-first-sample transition when wheel_in is already low.
REQ-026 SHALL discard any accumulated distance when reset is asserted mid-trip.

Structure
REQ-027 SHALL place MM_PER_PULSE (10000), the state encoding (IDLE, STOPPED, MOVING) and counter widths in shared package taxi_pkg.
REQ-028 SHALL implement synchronizer plus debounce as sub-module sensor_debounce (ports clk, rst_n, din, level, rise).

Verification
REQ-029 SHALL check: circ_mm=2000, en=1, five clean revolutions -> exactly one ten_meter_pulse, one cycle after the 5th event; acc_mm=0.
REQ-030 SHALL check: circ_mm=3000, four revolutions -> pulse after the 4th; acc_mm=2000; two more revolutions -> no pulse; acc_mm=8000.
REQ-031 SHALL check: DEBOUNCE_CYCLES=4, wheel_in glitches high for 3 cycles -> no revolution event and no state change.
REQ-032 SHALL check: STOP_TIMEOUT=1000, after MOVING no revolutions -> wait_en rises after 1000 cycles; the next revolution drops wait_en and raises moving.
REQ-033 SHALL check: revolution event on the same cycle the idle counter reaches STOP_TIMEOUT -> state stays MOVING, wait_en stays 0.
REQ-034 SHALL check: rst_n pulsed low with acc_mm=9000 -> all outputs 0 immediately; after release and en high, 5 revolutions at circ_mm=2000 give exactly one pulse.

Source files
------------

// File: rtl/taxi_pkg.sv
// Shared constants, counter widths and state encoding for the taxi distance/fare path.
package taxi_pkg;

    localparam int unsigned MM_PER_PULSE = 10000;
    localparam int unsigned CIRC_W       = 12;
    localparam int unsigned ACC_W        = 14;
    localparam int unsigned IDLE_W       = 26;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STOPPED = 2'd1,
        MOVING  = 2'd2
    } state_t;

endpackage

// File: rtl/distance_pulse_gen_if.sv
// Trip-control and distance/wait signal bundle between the wheel sensor side and the fare block.
interface distance_pulse_gen_if;
    import taxi_pkg::*;

    logic              en;
    logic              wheel_in;
    logic [CIRC_W-1:0] circ_mm;
    logic              ten_meter_pulse;
    logic              wait_en;
    logic              moving;

    modport master (output en, wheel_in, circ_mm,
                    input  ten_meter_pulse, wait_en, moving);
    modport slave  (input  en, wheel_in, circ_mm,
                    output ten_meter_pulse, wait_en, moving);

endinterface

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer plus consecutive-cycle debounce; rise is a one-cycle 0->1 event.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/distance_pulse_gen.sv
// Converts wheel revolutions into 10 m pulses and tracks stopped/moving for the fare block.
module distance_pulse_gen
    import taxi_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned STOP_TIMEOUT    = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wheel_in,
    input  logic [CIRC_W-1:0] circ_mm,
    output logic              ten_meter_pulse,
    output logic              wait_en,
    output logic              moving
);

    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(STOP_TIMEOUT);
    localparam logic [ACC_W-1:0]  ACC_WRAP   = ACC_W'(MM_PER_PULSE);

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d, sum_c;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              pulse_q, pulse_d;
    logic              wait_q, wait_d;
    logic              moving_q, moving_d;
    logic              rev_c;
    logic              level_unused;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (wheel_in),
        .level (level_unused),
        .rise  (rev_c)
    );

    // Max 9999 + 4095 fits in 14 bits, so at most one wrap per revolution.
    assign sum_c = acc_q + ACC_W'(circ_mm);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            idle_q   <= '0;
            pulse_q  <= 1'b0;
            wait_q   <= 1'b0;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idle_q   <= idle_d;
            pulse_q  <= pulse_d;
            wait_q   <= wait_d;
            moving_q <= moving_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idle_d  = idle_q;
        pulse_d = 1'b0;
        if (!en) begin
            state_d = IDLE;
            acc_d   = '0;
            idle_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = STOPPED;
                    acc_d   = '0;
                    idle_d  = '0;
                end
                STOPPED, MOVING: begin
                    // A revolution wins over a simultaneous timeout.
                    if (rev_c) begin
                        state_d = MOVING;
                        idle_d  = '0;
                        if (sum_c >= ACC_WRAP) begin
                            acc_d   = sum_c - ACC_WRAP;
                            pulse_d = 1'b1;
                        end else begin
                            acc_d = sum_c;
                        end
                    end else begin
                        if (idle_q != IDLE_LIMIT) begin
                            idle_d = idle_q + IDLE_W'(1);
                        end
                        if (state_q == MOVING && idle_q == IDLE_LIMIT) begin
                            state_d = STOPPED;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    idle_d  = '0;
                end
            endcase
        end
        wait_d   = (state_d == STOPPED);
        moving_d = (state_d == MOVING);
    end

    assign ten_meter_pulse = pulse_q;
    assign wait_en         = wait_q;
    assign moving          = moving_q;

endmodule

// File: tb/tb_distance_pulse_gen.sv
// Directed bench for distance_pulse_gen with a revolution scoreboard and accumulator model.
module tb_distance_pulse_gen;
    import taxi_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    distance_pulse_gen_if bus();

    distance_pulse_gen #(.DEBOUNCE_CYCLES(4), .STOP_TIMEOUT(1000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (bus.en),
        .wheel_in        (bus.wheel_in),
        .circ_mm         (bus.circ_mm),
        .ten_meter_pulse (bus.ten_meter_pulse),
        .wait_en         (bus.wait_en),
        .moving          (bus.moving)
    );

    int checks = 0;
    int passed = 0;
    int acc_m  = 0;
    bit active_m = 1'b0;
    int exp_q[$];
    int pulse_cnt = 0;
    int wait_hi   = 0;

    always @(negedge clk) begin
        if (bus.ten_meter_pulse === 1'b1) pulse_cnt++;
        if (bus.wait_en === 1'b1) wait_hi++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One clean revolution; pulse, if due, must appear 2 sync + 4 debounce + 1 cycles after the edge.
    task automatic rev(input int c, input string tag);
        int sum, first_k, hits, obs;
        first_k = 0;
        hits    = 0;
        bus.circ_mm = 12'(c);
        if (active_m) begin
            sum = acc_m + c;
            if (sum >= 10000) begin
                acc_m = sum - 10000;
                exp_q.push_back(1);
            end else begin
                acc_m = sum;
                exp_q.push_back(0);
            end
        end else begin
            exp_q.push_back(0);
        end
        bus.wheel_in = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            #1;
            if (bus.ten_meter_pulse === 1'b1) begin
                hits++;
                if (first_k == 0) first_k = k;
            end
            if (k == 8)  bus.wheel_in = 1'b0;
            if (k == 10) bus.circ_mm  = 12'($urandom_range(4095));
        end
        obs = (hits == 0) ? 0 : ((hits == 1 && first_k == 7) ? 1 : 2);
        check(tag, 32'(obs), 32'(exp_q.pop_front()));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int k, need;
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.wheel_in = 1'b0;
        bus.circ_mm  = 12'd2000;
        step(3);
        check("rst_pulse",  32'(bus.ten_meter_pulse), 0);
        check("rst_wait",   32'(bus.wait_en), 0);
        check("rst_moving", 32'(bus.moving), 0);
        check("rst_acc",    32'(dut.acc_q), 0);

        rst_n = 1'b1;
        step(2);
        check("idle_wait", 32'(bus.wait_en), 0);

        bus.en   = 1'b1;
        active_m = 1'b1;
        step(1);
        check("stopped_wait",   32'(bus.wait_en), 1);
        check("stopped_moving", 32'(bus.moving), 0);

        // Five revolutions of 2000 mm: single pulse on the fifth.
        pulse_cnt = 0;
        for (int i = 0; i < 5; i++) rev(2000, "rev2000");
        check("r2000_pulses", 32'(pulse_cnt), 1);
        check("r2000_acc",    32'(dut.acc_q), 32'(acc_m));
        check("r2000_moving", 32'(bus.moving), 1);
        check("r2000_wait",   32'(bus.wait_en), 0);

        pulse_cnt = 0;
        for (int i = 0; i < 4; i++) rev(3000, "rev3000");
        check("r3000_pulses", 32'(pulse_cnt), 1);
        check("r3000_acc",    32'(dut.acc_q), 2000);
        pulse_cnt = 0;
        for (int i = 0; i < 2; i++) rev(3000, "rev3000b");
        check("r3000b_pulses", 32'(pulse_cnt), 0);
        check("r3000b_acc",    32'(dut.acc_q), 8000);

        rev(4095, "rev_max");
        check("max_acc", 32'(dut.acc_q), 2095);
        rev(0, "rev_zero");
        check("zero_acc",    32'(dut.acc_q), 2095);
        check("zero_moving", 32'(bus.moving), 1);

        // Three-cycle glitch must not register a revolution.
        pulse_cnt   = 0;
        wait_hi     = 0;
        bus.circ_mm = 12'd1000;
        bus.wheel_in = 1'b1;
        step(3);
        bus.wheel_in = 1'b0;
        step(12);
        check("glitch_pulses", 32'(pulse_cnt), 0);
        check("glitch_acc",    32'(dut.acc_q), 2095);
        check("glitch_moving", 32'(bus.moving), 1);
        check("glitch_wait",   32'(wait_hi), 0);

        // Revolution lands exactly when the idle counter hits the timeout.
        wait_hi = 0;
        rev(0, "coinc_a");
        step(1001 - 18);
        rev(0, "coinc_b");
        check("coinc_wait",   32'(wait_hi), 0);
        check("coinc_moving", 32'(bus.moving), 1);

        // No revolutions: stopped after the timeout.
        step(985);
        check("pre_timeout_wait", 32'(bus.wait_en), 0);
        k = 0;
        while (bus.wait_en !== 1'b1 && k < 40) begin
            step(1);
            k++;
        end
        check("timeout_wait",   32'(bus.wait_en), 1);
        check("timeout_moving", 32'(bus.moving), 0);
        rev(1500, "resume");
        check("resume_wait",   32'(bus.wait_en), 0);
        check("resume_moving", 32'(bus.moving), 1);

        for (int i = 0; i < 10 && acc_m != 9000; i++) begin
            need = (9000 - acc_m + 10000) % 10000;
            rev((need > 4095) ? 4095 : need, "to9000");
        end
        check("acc9000", 32'(dut.acc_q), 9000);

        // Mid-trip asynchronous reset.
        #2;
        rst_n = 1'b0;
        acc_m = 0;
        #1;
        check("midrst_pulse",  32'(bus.ten_meter_pulse), 0);
        check("midrst_wait",   32'(bus.wait_en), 0);
        check("midrst_moving", 32'(bus.moving), 0);
        check("midrst_acc",    32'(dut.acc_q), 0);
        step(2);
        rst_n = 1'b1;
        step(2);
        check("postrst_wait", 32'(bus.wait_en), 1);
        pulse_cnt = 0;
        for (int i = 0; i < 5; i++) rev(2000, "postrst");
        check("postrst_pulses", 32'(pulse_cnt), 1);
        check("postrst_acc",    32'(dut.acc_q), 0);

        // Trip off: idle, revolutions ignored.
        bus.en   = 1'b0;
        active_m = 1'b0;
        step(1);
        check("off_wait",   32'(bus.wait_en), 0);
        check("off_moving", 32'(bus.moving), 0);
        rev(3000, "off_rev");
        check("off_acc",        32'(dut.acc_q), 0);
        check("off_rev_moving", 32'(bus.moving), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
